// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM state encoding and
// the default dwell-count width.
package decoder_scan_ctrl_pkg;

  localparam int DIV_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/decoder_scan_ctrl_mask_next_sel.sv
// Picks the next enabled decoder line: the lowest set mask bit strictly above
// cur, or the lowest set bit overall when from_start is high.
module mask_next_sel (
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  input  logic       from_start,
  output logic [1:0] nxt,
  output logic       found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    nxt   = 2'd0;
    found = 1'b0;
    // Walk downwards so the last hit left standing is the lowest qualifying bit.
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (from_start || (2'(i) > cur))) begin
        nxt   = 2'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer feeding the 2-to-4 decoder: walks the enabled lines in index
// order, holds each for div+1 cycles, then blanks for one cycle with en=0.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       mask,
  output logic             en,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done
);

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       idx_q, idx_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       step_idx, first_idx;
  logic             step_found, first_found;

  // Next line within the current pass, from the latched mask.
  mask_next_sel u_step (
    .mask       (mask_q),
    .cur        (idx_q),
    .from_start (1'b0),
    .nxt        (step_idx),
    .found      (step_found)
  );

  // First line of a fresh pass, from the live mask (start and wrap points).
  mask_next_sel u_first (
    .mask       (mask),
    .cur        (2'd0),
    .from_start (1'b1),
    .nxt        (first_idx),
    .found      (first_found)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          en_d   = 1'b0;
          busy_d = 1'b0;
          if (start) begin
            div_d  = div;
            mask_d = mask;
            if (first_found) begin
              state_d = ST_DWELL;
              idx_d   = first_idx;
              en_d    = 1'b1;
              busy_d  = 1'b1;
              cnt_d   = div;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        ST_DWELL: begin
          if (cnt_q == '0) begin
            state_d = ST_GAP;
            en_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end

        ST_GAP: begin
          if (step_found) begin
            state_d = ST_DWELL;
            idx_d   = step_idx;
            en_d    = 1'b1;
            cnt_d   = div_q;
          end else if (oneshot) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Continuous wrap: the mask is re-sampled, the dwell length is not.
            mask_d = mask;
            if (first_found) begin
              state_d = ST_DWELL;
              idx_d   = first_idx;
              en_d    = 1'b1;
              cnt_d   = div_q;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en   = en_q;
  assign a    = idx_q[1];
  assign b    = idx_q[0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: a constant vector table, directed
// corner-case sequences and random stimulus against a queue-based pass model.
module tb_decoder_scan_ctrl;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, stop, oneshot;
  logic [DIV_W-1:0] div;
  logic [3:0]       mask;
  logic             en, a, b, busy, done;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DIV_W(DIV_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .oneshot (oneshot),
    .div     (div),
    .mask    (mask),
    .en      (en),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a scan is a queue of per-cycle slots, one pass at a time.
  typedef struct packed {
    logic       en;
    logic [1:0] idx;
  } slot_t;

  slot_t            q[$];
  logic             m_en = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [1:0]       m_idx = 2'd0;
  logic [DIV_W-1:0] m_div = '0;

  function automatic void build_pass(input logic [3:0] m, input logic [DIV_W-1:0] d);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        for (int k = 0; k <= int'(d); k++) q.push_back('{en: 1'b1, idx: 2'(i)});
        q.push_back('{en: 1'b0, idx: 2'(i)});
      end
    end
  endfunction

  task automatic model_edge();
    slot_t s;
    m_done = 1'b0;
    if (rst) begin
      q.delete();
      m_en = 1'b0; m_busy = 1'b0; m_idx = 2'd0; m_div = '0;
    end else if (stop) begin
      q.delete();
      m_en = 1'b0; m_busy = 1'b0;
    end else begin
      if (m_busy && q.size() == 0) begin
        if (oneshot) begin
          m_busy = 1'b0; m_done = 1'b1; m_en = 1'b0;
        end else begin
          build_pass(mask, m_div);
          if (q.size() == 0) begin
            m_busy = 1'b0; m_en = 1'b0;
          end
        end
      end else if (!m_busy && start) begin
        m_div = div;
        build_pass(mask, div);
        if (q.size() == 0) m_done = 1'b1;
        else m_busy = 1'b1;
      end
      if (q.size() != 0) begin
        s = q.pop_front();
        m_en = s.en; m_idx = s.idx;
      end
    end
  endtask

  // One clock: inputs are stable at the edge, outputs are sampled on the falling edge.
  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check({name, " vs model"}, 32'({en, a, b, busy, done}), 32'({m_en, m_idx, m_busy, m_done}));
  endtask

  typedef struct {
    logic             start;
    logic [DIV_W-1:0] div;
    logic [3:0]       mask;
    logic             en;
    logic [1:0]       idx;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t       tbl[10];
  logic [4:0] ref_tr[12];
  int         n_idx1, n_idx3, n_other, done_at;
  logic [1:0] seen[$];

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b1; div = '0; mask = '0;

    // Full one-shot pass, mask 1111, div 0.
    tbl[0] = '{1'b1, 8'd0, 4'hf, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 4'hf, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 4'hf, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 4'hf, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 4'hf, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'd0, 4'hf, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'd0, 4'hf, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'd0, 4'hf, 1'b0, 2'd3, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'd0, 4'hf, 1'b0, 2'd3, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'd0, 4'hf, 1'b0, 2'd3, 1'b0, 1'b0};

    step("reset0");
    step("reset1");
    check("reset state", 32'({en, a, b, busy, done}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; div = tbl[i].div; mask = tbl[i].mask; oneshot = 1'b1;
      step("table");
      check($sformatf("table row %0d", i), 32'({en, a, b, busy, done}),
            32'({tbl[i].en, tbl[i].idx, tbl[i].busy, tbl[i].done}));
      if (tbl[i].en) check($sformatf("decoder out row %0d", i), 32'(4'b0001 << {a, b}),
                           32'(4'b0001 << tbl[i].idx));
    end

    // Masked dwell: mask 1010, div 2; input changes after start must not matter.
    n_idx1 = 0; n_idx3 = 0; n_other = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      start = (i == 0);
      mask  = (i == 0) ? 4'b1010 : 4'hf;
      div   = (i == 0) ? 8'd2 : 8'd0;
      step("masked");
      ref_tr[i] = {m_en, m_idx, m_busy, m_done};
      if (en && {a, b} == 2'd1) n_idx1++;
      else if (en && {a, b} == 2'd3) n_idx3++;
      else if (en) n_other++;
      if (done) done_at = i;
    end
    check("masked idx1 dwell", 32'(n_idx1), 32'd3);
    check("masked idx3 dwell", 32'(n_idx3), 32'd3);
    check("masked lines 0/2", 32'(n_other), 32'd0);
    check("masked done cycle", 32'(done_at), 32'd8);

    // Same run with a second start mid-dwell: timing must be unchanged.
    for (int i = 0; i < 12; i++) begin
      start = (i == 0) || (i == 2);
      mask  = (i == 0) ? 4'b1010 : 4'hf;
      div   = (i == 0) ? 8'd2 : 8'd0;
      step("restart");
      check($sformatf("start while busy c%0d", i), 32'({en, a, b, busy, done}), 32'(ref_tr[i]));
    end

    // Empty mask: immediate done, no busy or enable.
    start = 1'b1; mask = 4'b0000; div = 8'd3;
    step("empty");
    check("empty mask done", 32'({en, busy, done}), 32'b001);
    start = 1'b0;
    step("empty after");
    check("empty mask pulse width", 32'({en, busy, done}), 32'b000);

    // Continuous scan with a mask change that only lands at the wrap.
    seen.delete();
    oneshot = 1'b0; start = 1'b1; mask = 4'b0011; div = 8'd1;
    for (int i = 0; i < 9; i++) begin
      step("continuous");
      start = 1'b0;
      if (i == 1) mask = 4'b0100;
      if (en) seen.push_back({a, b});
      check($sformatf("continuous no done c%0d", i), 32'(done), 32'd0);
    end
    check("continuous enable count", 32'(seen.size()), 32'd6);
    if (seen.size() == 6) begin
      check("continuous idx seq", 32'({seen[0], seen[1], seen[2], seen[3], seen[4], seen[5]}),
            32'({2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2}));
    end

    // stop together with start mid-scan, then once more while idle.
    stop = 1'b1; start = 1'b1;
    step("stop");
    check("stop mid-scan", 32'({en, busy, done}), 32'b000);
    step("stop+start idle");
    check("stop wins over start", 32'({en, busy, done}), 32'b000);
    stop = 1'b0; start = 1'b0;
    step("after stop");
    check("no scan after stop", 32'({en, busy, done}), 32'b000);

    // Reset held for two cycles in the middle of a scan.
    oneshot = 1'b1; start = 1'b1; mask = 4'hf; div = 8'd5;
    step("pre-reset");
    start = 1'b0;
    step("pre-reset");
    rst = 1'b1;
    step("reset mid");
    check("reset mid-scan", 32'({en, a, b, busy, done}), 32'd0);
    step("reset mid");
    rst = 1'b0;
    step("post reset");
    check("post reset idle", 32'({en, a, b, busy, done}), 32'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(499) == 0);
      start = ($urandom_range(5) == 0);
      stop  = ($urandom_range(59) == 0);
      if ($urandom_range(9) == 0) oneshot = 1'($urandom);
      if ($urandom_range(3) == 0) mask = 4'($urandom);
      div   = 8'($urandom_range(3));
      step("random");
      if (en) check("random en implies busy", 32'(busy), 32'd1);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
